// File: rtl/wgt_recirc_rf_array_if.sv
// -----------------------------------------------------------------------------
// wgt_recirc_rf_array_if
// Bundles the load/replay/control signals of the weight recirculation register
// file. The master side (weight buffer / sequencer) drives configuration, load
// beats and replay enable. The slave side (the register file) returns
// load_ready, the replay data and status flags.
//   cfg_len    : active chain length, sampled on accepted load_start
//   load_start : begin a (re)load of all channels
//   load_valid : data_in carries one word per channel
//   load_ready : load beats are accepted
//   data_in    : channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   run_en     : replay enable
//   clear      : synchronous flush to empty
//   data_out   : registered replay word per channel, same packing as data_in
//   out_valid  : one pulse per replayed word
//   pass_done  : pulse accompanying the last word of each pass
//   loaded     : chain contents valid for replay
// -----------------------------------------------------------------------------
interface wgt_recirc_rf_array_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CH     = 4,
   parameter int MAX_DEPTH  = 32,
   parameter int LEN_W      = $clog2(MAX_DEPTH + 1)
);
   logic [LEN_W-1:0]             cfg_len;
   logic                         load_start;
   logic                         load_valid;
   logic                         load_ready;
   logic [NUM_CH*DATA_WIDTH-1:0] data_in;
   logic                         run_en;
   logic                         clear;
   logic [NUM_CH*DATA_WIDTH-1:0] data_out;
   logic                         out_valid;
   logic                         pass_done;
   logic                         loaded;

   modport master (
      output cfg_len, load_start, load_valid, data_in, run_en, clear,
      input  load_ready, data_out, out_valid, pass_done, loaded
   );

   modport slave (
      input  cfg_len, load_start, load_valid, data_in, run_en, clear,
      output load_ready, data_out, out_valid, pass_done, loaded
   );
endinterface

// File: rtl/wgt_recirc_rf_array.sv
// -----------------------------------------------------------------------------
// wgt_recirc_rf_array
// Multi-channel recirculating weight register file. Each channel is a shift
// chain of MAX_DEPTH words. It is loaded once with len_q words and then
// replayed indefinitely by feeding the tap (entry len_q-1) back into entry 0.
// All channels share one controller.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   wif : slave side of wgt_recirc_rf_array_if (config, load beats, replay)
// -----------------------------------------------------------------------------
module wgt_recirc_rf_array #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CH     = 4,
   parameter int MAX_DEPTH  = 32,
   parameter int LEN_W      = $clog2(MAX_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   wgt_recirc_rf_array_if.slave wif
);
   localparam int               IDX_W   = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

   state_t                       state_q, state_d;
   logic [LEN_W-1:0]             len_q, len_d;
   logic [LEN_W-1:0]             beat_q, beat_d;
   logic [LEN_W-1:0]             pos_q, pos_d;
   logic                         loaded_q, loaded_d;
   logic                         load_ready_q, load_ready_d;
   logic                         out_valid_q, out_valid_d;
   logic                         pass_done_q, pass_done_d;
   logic [NUM_CH*DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic [NUM_CH*DATA_WIDTH-1:0] tap_w;
   logic                         shift_load, shift_run;
   logic                         flush;
   logic [LEN_W-1:0]             last_w;
   logic [LEN_W-1:0]             beat_inc;
   logic [IDX_W-1:0]             tap_idx;

   assign flush    = rst | wif.clear;
   assign last_w   = len_q - LEN_W'(1);
   assign beat_inc = beat_q + LEN_W'(1);
   // len_q is >= 1 whenever the tap is used, so the truncated index is in range.
   assign tap_idx  = last_w[IDX_W-1:0];

   // Next-state and output logic.
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      beat_d       = beat_q;
      pos_d        = pos_q;
      loaded_d     = loaded_q;
      load_ready_d = load_ready_q;
      out_valid_d  = 1'b0;
      pass_done_d  = 1'b0;
      data_out_d   = data_out_q;
      shift_load   = 1'b0;
      shift_run    = 1'b0;

      if (wif.clear) begin
         // Register clearing happens in the flush branch of the state register.
         state_d = IDLE;
      end else if (wif.load_start && (wif.cfg_len != '0)) begin
         len_d        = (wif.cfg_len > MAX_LEN) ? MAX_LEN : wif.cfg_len;
         beat_d       = '0;
         pos_d        = '0;
         loaded_d     = 1'b0;
         load_ready_d = 1'b1;
         data_out_d   = '0;   // output reads 0 while a load is in progress
         state_d      = LOAD;
      end else begin
         unique case (state_q)
            IDLE: ;
            LOAD: begin
               if (wif.load_valid && load_ready_q) begin
                  shift_load = 1'b1;
                  beat_d     = beat_inc;
                  if (beat_inc == len_q) begin
                     state_d      = READY;
                     loaded_d     = 1'b1;
                     load_ready_d = 1'b0;
                  end
               end
            end
            READY: begin
               if (wif.run_en) begin
                  shift_run   = 1'b1;
                  data_out_d  = tap_w;
                  out_valid_d = 1'b1;
                  if (pos_q == last_w) begin
                     pass_done_d = 1'b1;
                     pos_d       = '0;
                  end else begin
                     pos_d = pos_q + LEN_W'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and control registers.
   always_ff @(posedge clk) begin
      if (flush) begin
         state_q      <= IDLE;
         len_q        <= '0;
         beat_q       <= '0;
         pos_q        <= '0;
         loaded_q     <= 1'b0;
         load_ready_q <= 1'b0;
         out_valid_q  <= 1'b0;
         pass_done_q  <= 1'b0;
         data_out_q   <= '0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         beat_q       <= beat_d;
         pos_q        <= pos_d;
         loaded_q     <= loaded_d;
         load_ready_q <= load_ready_d;
         out_valid_q  <= out_valid_d;
         pass_done_q  <= pass_done_d;
         data_out_q   <= data_out_d;
      end
   end

   // Per-channel shift chains. Load beats enter at entry 0. During replay the
   // tap wraps around into entry 0, so the chain keeps its contents forever.
   // Entries beyond len_q-1 shift along but are never observed.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [DATA_WIDTH-1:0] chain_q [MAX_DEPTH];

         assign tap_w[gi*DATA_WIDTH +: DATA_WIDTH] = chain_q[tap_idx];

         always_ff @(posedge clk) begin
            if (flush) begin
               for (int i = 0; i < MAX_DEPTH; i++) begin
                  chain_q[i] <= '0;
               end
            end else if (shift_load || shift_run) begin
               chain_q[0] <= shift_load ? wif.data_in[gi*DATA_WIDTH +: DATA_WIDTH]
                                        : chain_q[tap_idx];
               for (int i = 1; i < MAX_DEPTH; i++) begin
                  chain_q[i] <= chain_q[i-1];
               end
            end
         end
      end
   endgenerate

   assign wif.data_out   = data_out_q;
   assign wif.out_valid  = out_valid_q;
   assign wif.pass_done  = pass_done_q;
   assign wif.loaded     = loaded_q;
   assign wif.load_ready = load_ready_q;
endmodule

// File: tb/tb_wgt_recirc_rf_array.sv
// -----------------------------------------------------------------------------
// tb_wgt_recirc_rf_array
// Directed bench for wgt_recirc_rf_array. Inputs are driven 1 ns after a
// rising edge, and outputs are checked 1 ns after the following rising edge.
// Lane c of a test word is base + stride*c, so every channel carries distinct
// data.
// -----------------------------------------------------------------------------
module tb_wgt_recirc_rf_array;
   localparam int DW = 8;
   localparam int NC = 4;
   localparam int MD = 32;
   localparam int LW = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wgt_recirc_rf_array_if #(.DATA_WIDTH(DW), .NUM_CH(NC), .MAX_DEPTH(MD), .LEN_W(LW)) wif ();

   wgt_recirc_rf_array #(.DATA_WIDTH(DW), .NUM_CH(NC), .MAX_DEPTH(MD), .LEN_W(LW)) dut (
      .clk (clk),
      .rst (rst),
      .wif (wif)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        ls;
      logic [5:0]  len;
      logic        lv;
      logic [31:0] din;
      logic        run;
      logic        clr;
      logic [31:0] e_dout;
      logic        e_ov;
      logic        e_pd;
      logic        e_ld;
      logic        e_rdy;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [31:0] pk(input int base, input int stride);
      logic [31:0] r;
      for (int c = 0; c < NC; c++) r[c*DW +: DW] = 8'(base + stride*c);
      return r;
   endfunction

   function automatic vec_t mk(input logic ls, input int len, input logic lv,
                               input logic [31:0] din, input logic run, input logic clr,
                               input logic [31:0] e_dout, input logic e_ov, input logic e_pd,
                               input logic e_ld, input logic e_rdy);
      vec_t v;
      v.ls = ls; v.len = 6'(len); v.lv = lv; v.din = din; v.run = run; v.clr = clr;
      v.e_dout = e_dout; v.e_ov = e_ov; v.e_pd = e_pd; v.e_ld = e_ld; v.e_rdy = e_rdy;
      return v;
   endfunction

   task automatic drv(input logic ls, input int len, input logic lv,
                      input logic [31:0] din, input logic run, input logic clr);
      wif.load_start = ls;
      wif.cfg_len    = 6'(len);
      wif.load_valid = lv;
      wif.data_in    = din;
      wif.run_en     = run;
      wif.clear      = clr;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One line per transaction, followed by the field comparisons.
   task automatic chk_out(input string tag, input logic [31:0] e_dout, input logic e_ov,
                          input logic e_pd, input logic e_ld, input logic e_rdy);
      $display("%s: dout=%h ov=%b pd=%b loaded=%b rdy=%b", tag, wif.data_out,
               wif.out_valid, wif.pass_done, wif.loaded, wif.load_ready);
      chk({tag, " data_out"},   wif.data_out,   e_dout);
      chk({tag, " out_valid"},  {31'd0, wif.out_valid},  {31'd0, e_ov});
      chk({tag, " pass_done"},  {31'd0, wif.pass_done},  {31'd0, e_pd});
      chk({tag, " loaded"},     {31'd0, wif.loaded},     {31'd0, e_ld});
      chk({tag, " load_ready"}, {31'd0, wif.load_ready}, {31'd0, e_rdy});
   endtask

   initial begin
      // Stalled replay with L=3, cfg_len=0 ignored, L=1, then clear with load_start.
      tbl.push_back(mk(1, 3, 0, 0,         0, 0, 0,          0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 1, pk(5,16),  0, 0, 0,          0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 1, pk(6,16),  0, 0, 0,          0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 1, pk(7,16),  0, 0, 0,          0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0,         1, 0, pk(5,16),   1, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0,         0, 0, pk(5,16),   0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0,         1, 0, pk(6,16),   1, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0,         1, 0, pk(7,16),   1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0,         0, 0, pk(7,16),   0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0,         1, 0, pk(5,16),   1, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0,         1, 0, pk(6,16),   1, 0, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0,         0, 0, pk(6,16),   0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0,         1, 0, pk(7,16),   1, 1, 1, 0));
      tbl.push_back(mk(1, 1, 0, 0,         0, 0, 0,          0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 1, pk(8'hAA,16), 0, 0, 0,       0, 0, 1, 0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0, 0, 0, 0,      1, 0, pk(8'hAA,16), 1, 1, 1, 0));
      tbl.push_back(mk(1, 5, 0, 0,         1, 1, 0,          0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, pk(9,16),  1, 0, 0,          0, 0, 0, 0));

      // Reset and idle behaviour.
      drv(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      cyc();
      cyc();
      chk_out("reset", 0, 0, 0, 0, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drv(0, 0, 1, pk(i+1,16), 1, 0);
         cyc();
         chk_out($sformatf("idle%0d", i), 0, 0, 0, 0, 0);
      end

      // Table-driven vectors.
      foreach (tbl[i]) begin
         drv(tbl[i].ls, int'(tbl[i].len), tbl[i].lv, tbl[i].din, tbl[i].run, tbl[i].clr);
         cyc();
         chk_out($sformatf("row%0d", i), tbl[i].e_dout, tbl[i].e_ov, tbl[i].e_pd,
                 tbl[i].e_ld, tbl[i].e_rdy);
      end

      // Basic load (L=9) and 20-cycle continuous replay.
      drv(1, 9, 0, 0, 0, 0);
      cyc();
      chk_out("basic start", 0, 0, 0, 0, 1);
      for (int k = 0; k < 9; k++) begin
         drv(0, 0, 1, pk(k,16), 0, 0);
         cyc();
         chk_out($sformatf("basic beat%0d", k), 0, 0, 0, k == 8, k != 8);
      end
      for (int j = 0; j < 20; j++) begin
         drv(0, 0, 0, 0, 1, 0);
         cyc();
         chk_out($sformatf("basic run%0d", j), pk(j % 9, 16), 1, (j % 9) == 8, 1, 0);
      end

      // Advance to position 4, then reload with L=5 while run_en is high.
      for (int j = 20; j < 22; j++) begin
         drv(0, 0, 0, 0, 1, 0);
         cyc();
         chk_out($sformatf("basic run%0d", j), pk(j % 9, 16), 1, 0, 1, 0);
      end
      drv(1, 5, 0, 0, 1, 0);
      cyc();
      chk_out("reload start", 0, 0, 0, 0, 1);
      for (int k = 0; k < 5; k++) begin
         drv(0, 0, 1, pk(100+k,16), 1, 0);
         cyc();
         chk_out($sformatf("reload beat%0d", k), 0, 0, 0, k == 4, k != 4);
      end
      for (int j = 0; j < 7; j++) begin
         drv(0, 0, 0, 0, 1, 0);
         cyc();
         chk_out($sformatf("reload run%0d", j), pk(100 + j % 5, 16), 1, (j % 5) == 4, 1, 0);
      end

      // cfg_len=40 clamps to 32.
      drv(1, 40, 0, 0, 0, 0);
      cyc();
      chk_out("clamp start", 0, 0, 0, 0, 1);
      for (int k = 0; k < 32; k++) begin
         drv(0, 0, 1, pk(k,64), 0, 0);
         cyc();
         chk_out($sformatf("clamp beat%0d", k), 0, 0, 0, k == 31, k != 31);
      end
      for (int j = 0; j < 33; j++) begin
         drv(0, 0, 0, 0, 1, 0);
         cyc();
         chk_out($sformatf("clamp run%0d", j), pk(j % 32, 64), 1, (j % 32) == 31, 1, 0);
      end

      // Reset mid-replay.
      drv(0, 0, 0, 0, 1, 0);
      rst = 1'b1;
      cyc();
      chk_out("rst midrun", 0, 0, 0, 0, 0);
      rst = 1'b0;

      // Mid-load abort by clear after 3 of 9 beats.
      drv(1, 9, 0, 0, 0, 0);
      cyc();
      chk_out("abort start", 0, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         drv(0, 0, 1, pk(k+1,16), 0, 0);
         cyc();
         chk_out($sformatf("abort beat%0d", k), 0, 0, 0, 0, 1);
      end
      drv(0, 0, 1, pk(4,16), 0, 1);
      cyc();
      chk_out("abort clear", 0, 0, 0, 0, 0);
      for (int j = 0; j < 3; j++) begin
         drv(0, 0, 1, pk(5,16), 1, 0);
         cyc();
         chk_out($sformatf("abort run%0d", j), 0, 0, 0, 0, 0);
      end

      drv(0, 0, 0, 0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/wgt_recirc_rf_array.md
# wgt_recirc_rf_array

Multi-channel, runtime-length weight register file for the systolic array's weight feed. It holds one recirculating shift chain per channel. A chain is loaded once with a filter's weights and then replayed indefinitely, one word per enabled shift. The replay length is programmable per load (cfg_len ≤ MAX_DEPTH), so one instance serves kernels of different sizes (e.g. 9, 27, 75 weights) without re-synthesis. It sits between the weight buffer read port and the column inputs of the PE array.

## Interface
- DATA_WIDTH, 8, bits per weight word
- NUM_CH, 4, independent channels (one per array column/filter), all sharing control
- MAX_DEPTH, 32, physical entries per channel
- LEN_W, $clog2(MAX_DEPTH+1), width of cfg_len and internal counters

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_len  in  LEN_W  active chain length, sampled only on accepted load_start
- load_start  in  1  begin a (re)load of all channels
- load_valid  in  1  data_in carries one word per channel
- load_ready  out  1  block accepts load beats (registered)
- data_in  in  NUM_CH*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- run_en  in  1  shift/replay enable
- clear  in  1  synchronous flush to empty
- data_out  out  NUM_CH*DATA_WIDTH  registered replay output, same packing
- out_valid  out  1  one-cycle pulse per replayed word
- pass_done  out  1  one-cycle pulse with the last word of each pass
- loaded  out  1  chain contents valid for replay

## Operation
- The state machine has three states: IDLE, LOAD and READY. Reset and clear both go to IDLE.
- Reset and clear are identical in effect: all buffer entries, data_out, out_valid, pass_done, loaded, load_ready, the counters and len_q are cleared to 0.
- Priority per cycle: rst > clear > load_start > load beat / run_en.
- Accepted load_start (any state, cfg_len≠0):
  - len_q ← min(cfg_len, MAX_DEPTH).
  - Beat counter ← 0, position counter ← 0, loaded ← 0.
  - Next state is LOAD.
- load_start with cfg_len=0 is ignored, and the state is unchanged.
- LOAD:
  - load_ready=1.
  - Each beat (load_valid & load_ready) shifts every channel: buf[i] ← buf[i-1] for i ≥ 1, and buf[0] ← data_in lane.
  - The beat counter increments per beat.
  - On the beat that brings the count to len_q: next state READY, loaded ← 1, load_ready ← 0.
  - run_en is ignored in LOAD. data_out and out_valid hold 0.
- READY:
  - Each cycle with run_en=1 does all of the following on every channel:
    - data_out lane ← buf[len_q-1] (the tap).
    - buf[i] ← buf[i-1] for i ≥ 1.
    - buf[0] ← buf[len_q-1].
  - Entries at index ≥ len_q shift but are never tapped; they are don't-care.
  - out_valid=1 for every run_en cycle.
  - The position counter counts 0..len_q-1 and wraps. pass_done=1 on the cycle whose output is position len_q-1.
  - With run_en=0: buffers, data_out and the counters hold, and out_valid=pass_done=0.
- IDLE: load beats and run_en are ignored. data_out is held at 0.
- Replay order: if the loaded words are w0..w(L-1) in beat order, the output is w0, w1, …, w(L-1), w0, … with no gap across the wrap.
- L=1 case: every run_en cycle outputs w0, and pass_done is asserted on every run_en cycle.
- Reload from READY: loaded drops in the cycle after load_start. Old contents are shifted out by the new beats.

## Timing
- Load beat accepted at edge t: the word is in buf[0] after edge t.
- Final beat at edge t: state=READY and loaded=1 after edge t. run_en may be asserted in the same cycle loaded first reads 1.
- Replay latency is 1 cycle: run_en sampled high at edge t gives data_out/out_valid/pass_done valid after edge t, cleared after edge t+1 unless run_en is high again.
- load_ready is registered: it is 1 from the edge after an accepted load_start, and 0 from the edge of the final beat.
- clear or rst mid-load or mid-replay takes effect at that edge: all outputs read 0 in the next cycle.

## Test plan
- Reset/idle: assert rst for 2 cycles, then pulse run_en and load_valid in IDLE -> data_out=0, out_valid=0, loaded=0, load_ready=0 throughout.
- Basic load and replay, NUM_CH=4, cfg_len=9:
  - Stimulus: load words ch c, beat k = 16*c+k, then hold run_en high for 20 cycles.
  - Expected: ch2 outputs 32..40, 32..40, 32, 33; out_valid high 20 cycles; pass_done on cycles 9 and 18.
- Stalled replay, cfg_len=3, words 5,6,7, run_en pattern 1,0,1,1,0,1,1 -> outputs 5,(hold),6,7,(hold),5,6; pass_done only with 7.
- Length edges:
  - cfg_len=1, word 0xAA, 4 run_en cycles -> 0xAA every cycle, pass_done every cycle.
  - cfg_len=40 (>MAX_DEPTH 32) -> clamps to 32: loaded after 32 beats, pass every 32 outputs.
  - cfg_len=0 load_start -> ignored.
- Reload and priority:
  - In READY mid-pass (position 4 of 9), assert load_start with cfg_len=5 and run_en together -> no output that cycle, LOAD entered, 5 new beats, replay starts at new w0.
  - clear together with load_start -> IDLE, all outputs 0.
- Mid-load abort: clear after 3 of 9 beats -> IDLE, loaded=0. A later run_en produces no out_valid.
